// File: rtl/fp_add_sub.sv
// Floating-point adder/subtractor: fixed-latency align/add/normalise/round pipeline
// with valid/ready handshakes and internal NaN/infinity/zero handling.
module fp_add_sub #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic                    op_sub_i,
  input  logic [EXP_W+FRAC_W:0]   x_i,
  input  logic [EXP_W+FRAC_W:0]   y_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [EXP_W+FRAC_W:0]   z_o,
  output logic                    z_infinity_o,
  output logic                    z_nan_o,
  output logic                    z_zero_o
);

  localparam int unsigned W    = 1 + EXP_W + FRAC_W;
  localparam int unsigned MW   = FRAC_W + 4;
  localparam int unsigned SW   = MW + 1;
  localparam int unsigned EW   = EXP_W + 2;
  localparam int unsigned LZ_W = $clog2(MW + 1);
  localparam int          EMAX = (2 ** EXP_W) - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_HOLD
  } state_e;

  state_e state_q, state_d;

  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [W-1:0]         x_q, x_d, y_q, y_d;
  logic                 op_q, op_d;
  logic [MW-1:0]        ma_q, ma_d, mb_q, mb_d;
  logic [EXP_W-1:0]     ea_q, ea_d;
  logic                 sa_q, sa_d, sb_q, sb_d;
  logic                 spec_q, spec_d;
  logic [W-1:0]         spec_z_q, spec_z_d;
  logic [2:0]           spec_f_q, spec_f_d;
  logic [SW-1:0]        sum_q, sum_d;
  logic [MW-1:0]        nm_q, nm_d;
  logic signed [EW-1:0] ne_q, ne_d;
  logic [W-1:0]         z_q, z_d;
  logic                 nan_q, nan_d, inf_q, inf_d, zero_q, zero_d;

  // Operand decode (y sign already reflects the add/subtract select)
  logic               xs, ys;
  logic [EXP_W-1:0]   xe, ye, ea, eb, diff;
  logic [FRAC_W-1:0]  xf, yf, fa, fb;
  logic               x_zero, y_zero, x_nan, y_nan, x_inf, y_inf, x_ge, sa, sb;
  logic [MW-1:0]      mb_full, mb_shift;
  logic               b_sticky;

  assign xs      = x_q[W-1];
  assign ys      = y_q[W-1] ^ op_q;
  assign xe      = x_q[W-2:FRAC_W];
  assign ye      = y_q[W-2:FRAC_W];
  assign xf      = x_q[FRAC_W-1:0];
  assign yf      = y_q[FRAC_W-1:0];
  assign x_zero  = (xe == '0);
  assign y_zero  = (ye == '0);
  assign x_nan   = (&xe) & (|xf);
  assign y_nan   = (&ye) & (|yf);
  assign x_inf   = (&xe) & ~(|xf);
  assign y_inf   = (&ye) & ~(|yf);
  assign x_ge    = (x_q[W-2:0] >= y_q[W-2:0]);
  assign ea      = x_ge ? xe : ye;
  assign eb      = x_ge ? ye : xe;
  assign fa      = x_ge ? xf : yf;
  assign fb      = x_ge ? yf : xf;
  assign sa      = x_ge ? xs : ys;
  assign sb      = x_ge ? ys : xs;
  assign diff    = ea - eb;
  assign mb_full = {1'b1, fb, 3'b000};

  // Sticky right shift of the smaller mantissa
  always_comb begin
    b_sticky = 1'b0;
    for (int unsigned i = 0; i < MW; i++) begin
      if (i < 32'(diff)) b_sticky = b_sticky | mb_full[i];
    end
    if (32'(diff) >= MW) mb_shift = MW'(1);
    else                 mb_shift = (mb_full >> diff) | MW'(b_sticky);
  end

  // Special-case result, flags ordered {nan, inf, zero}
  logic         spec_hit;
  logic [W-1:0] spec_z;
  logic [2:0]   spec_f;

  always_comb begin
    spec_hit = 1'b1;
    spec_z   = '0;
    spec_f   = 3'b000;
    if (x_nan || y_nan || (x_inf && y_inf && (xs != ys))) begin
      spec_z = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
      spec_f = 3'b100;
    end else if (x_inf) begin
      spec_z = {xs, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      spec_f = 3'b010;
    end else if (y_inf) begin
      spec_z = {ys, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      spec_f = 3'b010;
    end else if (x_zero && y_zero) begin
      spec_z = {xs & ys, {(W-1){1'b0}}};
      spec_f = 3'b001;
    end else if (x_zero) begin
      spec_z = {ys, y_q[W-2:0]};
    end else if (y_zero) begin
      spec_z = x_q;
    end else if ((xs != ys) && (x_q[W-2:0] == y_q[W-2:0])) begin
      spec_f = 3'b001;
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Leading-zero count of the non-carry sum
  logic [LZ_W-1:0] lz;
  logic            lz_found;

  always_comb begin
    lz       = '0;
    lz_found = 1'b0;
    for (int unsigned i = 0; i < MW; i++) begin
      if (!lz_found) begin
        if (sum_q[MW-1-i]) lz_found = 1'b1;
        else               lz = lz + LZ_W'(1);
      end
    end
  end

  // Round to nearest even; hidden bit of nm_q clear marks an exact zero
  logic                 r_up, r_carry;
  logic [FRAC_W-1:0]    r_frac;
  logic signed [EW-1:0] r_exp;

  assign r_up              = nm_q[2] & (nm_q[1] | nm_q[0] | nm_q[3]);
  assign {r_carry, r_frac} = {1'b0, nm_q[MW-2:3]} + (FRAC_W+1)'(r_up);
  assign r_exp             = ne_q + EW'(r_carry);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid_i && in_ready_q) state_d = S_ALIGN;
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: state_d = S_HOLD;
      S_HOLD:  if (out_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs follow the next state
  always_comb begin
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_HOLD);
  end

  // Datapath stage updates
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    op_d     = op_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    ea_d     = ea_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    spec_d   = spec_q;
    spec_z_d = spec_z_q;
    spec_f_d = spec_f_q;
    sum_d    = sum_q;
    nm_d     = nm_q;
    ne_d     = ne_q;
    z_d      = z_q;
    nan_d    = nan_q;
    inf_d    = inf_q;
    zero_d   = zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid_i && in_ready_q) begin
          x_d  = x_i;
          y_d  = y_i;
          op_d = op_sub_i;
        end
      end
      S_ALIGN: begin
        ma_d     = {1'b1, fa, 3'b000};
        mb_d     = mb_shift;
        ea_d     = ea;
        sa_d     = sa;
        sb_d     = sb;
        spec_d   = spec_hit;
        spec_z_d = spec_z;
        spec_f_d = spec_f;
      end
      S_ADD: begin
        if (sa_q != sb_q) sum_d = {1'b0, ma_q} - {1'b0, mb_q};
        else              sum_d = {1'b0, ma_q} + {1'b0, mb_q};
      end
      S_NORM: begin
        if (sum_q[SW-1]) begin
          nm_d = {sum_q[SW-1:2], sum_q[1] | sum_q[0]};
          ne_d = EW'(ea_q) + EW'(1);
        end else if (sum_q == '0) begin
          nm_d = '0;
          ne_d = '0;
        end else begin
          nm_d = sum_q[MW-1:0] << lz;
          ne_d = EW'(ea_q) - EW'(lz);
        end
      end
      S_ROUND: begin
        {nan_d, inf_d, zero_d} = 3'b000;
        if (spec_q) begin
          z_d                    = spec_z_q;
          {nan_d, inf_d, zero_d} = spec_f_q;
        end else if (!nm_q[MW-1]) begin
          z_d    = '0;
          zero_d = 1'b1;
        end else if (int'(r_exp) <= 0) begin
          z_d    = {sa_q, {(W-1){1'b0}}};
          zero_d = 1'b1;
        end else if (int'(r_exp) >= EMAX) begin
          z_d   = {sa_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          inf_d = 1'b1;
        end else begin
          z_d = {sa_q, r_exp[EXP_W-1:0], r_frac};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      op_q        <= 1'b0;
      ma_q        <= '0;
      mb_q        <= '0;
      ea_q        <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      spec_q      <= 1'b0;
      spec_z_q    <= '0;
      spec_f_q    <= '0;
      sum_q       <= '0;
      nm_q        <= '0;
      ne_q        <= '0;
      z_q         <= '0;
      nan_q       <= 1'b0;
      inf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
      op_q        <= op_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      ea_q        <= ea_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      spec_q      <= spec_d;
      spec_z_q    <= spec_z_d;
      spec_f_q    <= spec_f_d;
      sum_q       <= sum_d;
      nm_q        <= nm_d;
      ne_q        <= ne_d;
      z_q         <= z_d;
      nan_q       <= nan_d;
      inf_q       <= inf_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = out_valid_q;
  assign z_o          = z_q;
  assign z_nan_o      = nan_q;
  assign z_infinity_o = inf_q;
  assign z_zero_o     = zero_q;

endmodule

// File: tb/tb_fp_add_sub.sv
// Directed self-checking bench for fp_add_sub with FP32 defaults.
module tb_fp_add_sub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op_sub = 1'b0;
  logic [31:0] x_in = '0;
  logic [31:0] y_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] z;
  logic        z_inf, z_nan, z_zero;

  int n_asserts = 0;
  int n_fails   = 0;

  always #5 clk = ~clk;

  fp_add_sub dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .op_sub_i     (op_sub),
    .x_i          (x_in),
    .y_i          (y_in),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .z_o          (z),
    .z_infinity_o (z_inf),
    .z_nan_o      (z_nan),
    .z_zero_o     (z_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one transaction and return #1 after its accepting edge
  task automatic launch(input logic [31:0] x, input logic [31:0] y, input logic op);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    x_in     = x;
    y_in     = y;
    op_sub   = op;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 20);
    chk("latency", 32'(lat), 32'd4);
  endtask

  // Flags ordered {nan, inf, zero}
  task automatic finish_op(input string tag, input logic [31:0] ez, input logic [2:0] ef);
    out_ready = 1'b1;
    wait_valid();
    chk({tag, "_z"}, z, ez);
    chk({tag, "_flags"}, 32'({z_nan, z_inf, z_zero}), 32'(ef));
    @(posedge clk);
    #1;
    chk({tag, "_valid_fall"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic op(input string tag, input logic [31:0] x, input logic [31:0] y,
                    input logic s, input logic [31:0] ez, input logic [2:0] ef);
    launch(x, y, s);
    finish_op(tag, ez, ef);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_valid;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_z", z, 32'h0);
    chk("rst_flags", 32'({z_nan, z_inf, z_zero}), 32'd0);
    rst = 1'b0;

    op("add_1_1",     32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
    op("cancel_pi",   32'h40490FDB, 32'h40490FDB, 1'b1, 32'h00000000, 3'b001);
    op("sub_lshift",  32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 3'b000);
    op("tie_even",    32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000);
    op("tie_up",      32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b000);
    op("sticky_up",   32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 3'b000);
    op("inf_m_inf",   32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100);
    op("overflow",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010);
    op("nan_in",      32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100);
    op("inf_p_one",   32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 3'b010);
    op("zero_m_one",  32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 3'b000);
    op("one_p_zero",  32'h3F800000, 32'h80000000, 1'b0, 32'h3F800000, 3'b000);
    op("denorm_ftz",  32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 3'b001);
    op("negz_negz",   32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b001);
    op("one_m_two",   32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000);
    op("underflow",   32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b001);
    op("far_shift",   32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 3'b000);

    // Backpressure: result held for 10 cycles, stray in_valid ignored
    out_ready = 1'b0;
    launch(32'h40000000, 32'h3F800000, 1'b0);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_valid = 1'b1;
        x_in     = 32'h3F800000;
        y_in     = 32'h3F800000;
      end
      if (i == 4) in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("hold_z", z, 32'h40400000);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_valid_fall", 32'(out_valid), 32'd0);
    chk("release_ready", 32'(in_ready), 32'd1);
    launch(32'h3F800000, 32'h3F800000, 1'b0);
    chk("next_accepted", 32'(in_ready), 32'd0);
    finish_op("after_hold", 32'h40000000, 3'b000);

    // Reset while in NORM aborts the transaction
    launch(32'h3F800000, 32'h3F800000, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_z", z, 32'h0);
    chk("abort_flags", 32'({z_nan, z_inf, z_zero}), 32'd0);
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid++;
    end
    chk("abort_no_valid", 32'(seen_valid), 32'd0);
    op("post_reset", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
